mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL: parameter STARVE_LIMIT, default 4; consecutive lost fetch cycles before fetch is forced to win (range 1..15).
REQ-002 SHALL: one clock; reset is asynchronous and active-low.
REQ-003 SHALL: clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL: rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL: if_req  input  1  instruction-fetch request; if_addr held stable until granted.
REQ-006 SHALL: if_addr  input  14  fetch word address.
REQ-007 SHALL: if_gnt  output  1  fetch request accepted this cycle (combinational).
REQ-008 SHALL: if_rvalid / if_rdata  output  1 / 32  fetch response pulse and registered read word.
REQ-009 SHALL: d_req, d_we  input  1, 1  data request; 1 = store, 0 = load; d_* fields held stable until granted.
REQ-010 SHALL: d_addr / d_wdata / d_type  input  14 / 32 / 3  data word address, store data, load/store type code.
REQ-011 SHALL: d_gnt  output  1  data request accepted this cycle (combinational).
REQ-012 SHALL: d_rvalid / d_rdata  output  1 / 32  data response pulse (loads and stores) and registered load word.
REQ-013 SHALL: m_is_store / m_addr / m_wdata / m_type  output  1 / 14 / 32 / 3  memory port command, driven from the command register.
REQ-014 SHALL: m_loaddata  input  32  combinational read data from memory.

Function
REQ-015 SHALL: FSM states IDLE, ACC_IF, ACC_D; the state reflects the command occupying the memory port in the current cycle.
REQ-016 SHALL: arbitration each cycle in any state; at most one of if_gnt/d_gnt high; a grant occurs iff the corresponding req is high and it wins.
REQ-017 SHALL: default priority: data beats fetch when both requests are high.
REQ-018 SHALL: on a grant at cycle N, latch the command at the rising edge ending N; next state ACC_IF or ACC_D; with no grant, next state IDLE.
REQ-019 SHALL: in cycle N+1, drive m_addr, m_type, and m_wdata from the command register; m_is_store=1 only in ACC_D with a latched store.
REQ-020 SHALL: at the rising edge ending N+1, capture m_loaddata into the owner's rdata; the owner's rvalid is 1 for exactly cycle N+2.
REQ-021 SHALL: for stores, d_rvalid pulses in N+2 and d_rdata keeps its previous value.
REQ-022 SHALL: throughput is one access per cycle; back-to-back grants keep the FSM in ACC states with no bubble.
REQ-023 SHALL: in IDLE, m_is_store=0, and m_addr, m_wdata, and m_type are 0.
REQ-024 SHALL: if_rdata and d_rdata hold their value between responses.
REQ-025 SHALL: the type code passes unmodified to m_type; no decoding or sign handling is done in this block.

Reset
REQ-026 SHALL: with rst_n low: state IDLE; if_gnt, d_gnt, if_rvalid, and d_rvalid are 0; if_rdata and d_rdata are 0; all m_* outputs are 0; the starvation counter is 0.
REQ-027 SHALL: reset mid-access discards the in-flight command, with no rvalid afterwards; m_is_store drops immediately (asynchronously).
REQ-028 SHALL: the first grant is possible in the first cycle after rst_n deasserts.

Configuration
REQ-029 SHALL: macro MEM_ARB_FAIRNESS_EN; when defined, a 4-bit counter increments each cycle if_req=1 and if_gnt=0, and clears on if_gnt or when if_req=0.
REQ-030 SHALL: with MEM_ARB_FAIRNESS_EN defined, once the counter reaches STARVE_LIMIT, fetch wins over data for that cycle, and the counter clears.
REQ-031 SHALL: with MEM_ARB_FAIRNESS_EN undefined, strict data priority applies and no counter logic is present; fetch may starve indefinitely.

Verification
REQ-032 SHALL: lone fetch with if_addr=0x0010, memory word 0x00000013 -> if_gnt in cycle 0, m_addr=0x0010 in cycle 1, if_rvalid=1 and if_rdata=0x00000013 in cycle 2.
REQ-033 SHALL: data store with d_addr=0x0100, d_wdata=0xDEADBEEF, followed by a load from 0x0100 -> m_is_store=1 for 1 cycle only, d_rvalid pulses twice, d_rdata=0xDEADBEEF.
REQ-034 SHALL: if_req and d_req high together for 1 access each -> d_gnt cycle 0, if_gnt cycle 1, rvalids in cycles 2 and 3.
REQ-035 SHALL: d_req held high for 10 cycles with if_req high and MEM_ARB_FAIRNESS_EN, STARVE_LIMIT=4 -> if_gnt in cycle 4; without the macro, no if_gnt in cycles 0..9.
REQ-036 SHALL: rst_n pulled low in the ACC_D store cycle -> m_is_store=0 immediately; no d_rvalid afterwards; state IDLE after release.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction fetch / data) single-port memory arbiter.
// Each cycle one request may be granted. The granted command is latched and
// presented on the memory port in the following cycle, and the response
// (rvalid plus read word) appears one cycle after that, so a new access can
// start every cycle.
// Data has priority over fetch by default.
// Optional feature: define MEM_ARB_FAIRNESS_EN to add a fetch starvation
// counter. When the counter reaches STARVE_LIMIT lost cycles, fetch wins the
// next arbitration.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction fetch port
  input  logic        if_req,
  input  logic [13:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  // data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [13:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_type,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  // memory port
  output logic        m_is_store,
  output logic [13:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [2:0]  m_type,
  input  logic [31:0] m_loaddata
);

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 3;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_IF = 2'd1,
    ACC_D  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   force_if;

  // Reject starvation limits the 4-bit counter cannot represent
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("mem_arbiter: STARVE_LIMIT must be in 1..15");
  end

`ifdef MEM_ARB_FAIRNESS_EN
  logic [CW-1:0] starve_cnt;

  assign force_if = if_req && (starve_cnt >= CW'(STARVE_LIMIT));

  // Count cycles fetch is requesting but losing; clear when it wins or drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // State register: which command owns the memory port this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state follows this cycle's grant; no grant means the port goes idle
  always_comb begin
    state_next = IDLE;
    if (d_gnt) begin
      state_next = ACC_D;
    end else if (if_gnt) begin
      state_next = ACC_IF;
    end
  end

  // Arbitration outputs: forced fetch, then data, then fetch; silent in reset
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (rst_n) begin
      if (force_if) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  // Command register driving the memory port; cleared when nothing is granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_is_store <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_type     <= '0;
    end else if (d_gnt) begin
      m_is_store <= d_we;
      m_addr     <= d_addr;
      m_wdata    <= d_wdata;
      m_type     <= d_type;
    end else if (if_gnt) begin
      m_is_store <= 1'b0;
      m_addr     <= if_addr;
      m_wdata    <= '0;
      m_type     <= '0;
    end else begin
      m_is_store <= 1'b0;
      m_addr     <= AW'(0);
      m_wdata    <= DW'(0);
      m_type     <= TW'(0);
    end
  end

  // Response stage: capture read data for the port owner and pulse its rvalid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= (state == ACC_IF);
      d_rvalid  <= (state == ACC_D);
      if (state == ACC_IF) begin
        if_rdata <= m_loaddata;
      end
      if (state == ACC_D && !m_is_store) begin
        d_rdata <= m_loaddata;
      end
    end
  end

endmodule
